c_selector_n_sync: RTL and testbench

- Parametrised clocked successor of the 4-way no-data selector: one input token stream demultiplexed to NUM_PORTS output ports, carrying a DATA_W payload.
- Each token carries its own one-hot select vector. One output register stage sits between the input side and the outputs.
- Used where the click-based selector moves into a clocked island. Adds illegal-select detection, a saturating drop counter and optional broadcast.

---
 rtl/c_selector_pkg.sv | 26 ++
 rtl/c_selector_n_sync_sat_counter.sv | 20 ++
 rtl/c_selector_n_sync.sv | 112 +++++++++++
 tb/tb_c_selector_n_sync.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/c_selector_pkg.sv
// Shared types and helpers for the clocked N-way selector family.
// Provides the FSM state enum and select-vector classification functions.
package c_selector_pkg;

  localparam int MAX_PORTS = 16;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  localparam logic [MAX_PORTS-1:0] ONE = MAX_PORTS'(1);

  function automatic logic is_zero(
    input logic [MAX_PORTS-1:0] vec
  );
    return vec == '0;
  endfunction

  function automatic logic is_onehot(
    input logic [MAX_PORTS-1:0] vec
  );
    return (vec != '0) && ((vec & (vec - ONE)) == '0);
  endfunction

endpackage

// File: rtl/c_selector_n_sync_sat_counter.sv
// Saturating up-counter, holds at all-ones.
// Ports: clk, rstn (async active-low), inc (count enable), cnt (value).
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/c_selector_n_sync.sv
// Clocked 1-to-NUM_PORTS token selector with one output register stage.
// Ports: i_drive/o_free input handshake with i_select/i_data;
// o_driveNext/i_freeNext per-port handshake sharing o_data;
// o_err pulses after an illegal select, o_drop_cnt counts drops.
// Define C_SELECTOR_N_BROADCAST_EN to accept multi-hot selects.
module c_selector_n_sync
  import c_selector_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_drive,
  output logic                 o_free,
  input  logic [NUM_PORTS-1:0] i_select,
  input  logic [DATA_W-1:0]    i_data,
  output logic [NUM_PORTS-1:0] o_driveNext,
  input  logic [NUM_PORTS-1:0] i_freeNext,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_err,
  output logic [CNT_W-1:0]     o_drop_cnt
);

  state_t                state;
  state_t                stateNext;
  logic [NUM_PORTS-1:0]  pm;
  logic [NUM_PORTS-1:0]  pmNext;
  logic [DATA_W-1:0]     dataQ;
  logic [DATA_W-1:0]     dataNext;
  logic                  errQ;
  logic [MAX_PORTS-1:0]  selExt;
  logic                  done;
  logic                  accept;
  logic                  legal;
  logic                  drop;

  assign selExt = MAX_PORTS'(i_select);

  // pm is zero in IDLE, so done is trivially true there.
  assign done   = (pm & ~i_freeNext) == '0;
  assign o_free = (state == IDLE) | ((state == HOLD) & done);
  assign accept = i_drive & o_free;

`ifdef C_SELECTOR_N_BROADCAST_EN
  assign legal = !is_zero(selExt);
`else
  assign legal = is_onehot(selExt);
`endif

  assign drop = accept & ~legal;

  always_comb begin
    stateNext = state;
    pmNext    = pm;
    dataNext  = dataQ;
    unique case (state)
      IDLE: begin
        pmNext = '0;
      end
      HOLD: begin
`ifdef C_SELECTOR_N_BROADCAST_EN
        pmNext = pm & ~i_freeNext;
`else
        pmNext = done ? '0 : pm;
`endif
        if (done) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        pmNext    = '0;
      end
    endcase
    // A new token overrides the retirement of the old one: no bubble.
    if (accept && legal) begin
      stateNext = HOLD;
      pmNext    = i_select;
      dataNext  = i_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      pm    <= '0;
      dataQ <= '0;
      errQ  <= 1'b0;
    end else begin
      state <= stateNext;
      pm    <= pmNext;
      dataQ <= dataNext;
      errQ  <= drop;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_dropCnt (
    .clk (clk),
    .rstn(rstn),
    .inc (drop),
    .cnt (o_drop_cnt)
  );

  assign o_driveNext = (state == HOLD) ? pm : '0;
  assign o_data      = dataQ;
  assign o_err       = errQ;

endmodule

// File: tb/tb_c_selector_n_sync.sv
// Scoreboard bench for c_selector_n_sync (NUM_PORTS=4, CNT_W=2).
// Directed tokens push expectations; a negedge monitor pops and compares.
module tb_c_selector_n_sync;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_drive = 1'b0;
  logic          o_free;
  logic [NP-1:0] i_select = '0;
  logic [DW-1:0] i_data = '0;
  logic [NP-1:0] o_driveNext;
  logic [NP-1:0] i_freeNext = '1;
  logic [DW-1:0] o_data;
  logic          o_err;
  logic [CW-1:0] o_drop_cnt;

  int nChecks = 0;
  int nFails  = 0;

  logic [NP-1:0] expDrv[$];
  logic [DW-1:0] expDat[$];
  logic [CW-1:0] expCnt[$];

  c_selector_n_sync #(
    .NUM_PORTS(NP),
    .DATA_W   (DW),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_drive    (i_drive),
    .o_free     (o_free),
    .i_select   (i_select),
    .i_data     (i_data),
    .o_driveNext(o_driveNext),
    .i_freeNext (i_freeNext),
    .o_data     (o_data),
    .o_err      (o_err),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [NP-1:0] d, input logic [DW-1:0] v);
    expDrv.push_back(d);
    expDat.push_back(v);
  endtask

  task automatic cyc(input logic d, input logic [NP-1:0] s,
                     input logic [DW-1:0] v, input logic [NP-1:0] f,
                     input logic ef);
    @(posedge clk);
    #1;
    i_drive    = d;
    i_select   = s;
    i_data     = v;
    i_freeNext = f;
    @(negedge clk);
    check("o_free", o_free, ef);
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (o_driveNext !== '0) begin
        if (expDrv.size() == 0) begin
          check("unexpected_valid", o_driveNext, 0);
        end else begin
          check("o_driveNext", o_driveNext, expDrv.pop_front());
          check("o_data", o_data, expDat.pop_front());
        end
      end
      if (o_err !== 1'b0) begin
        if (expCnt.size() == 0) begin
          check("unexpected_err", o_err, 0);
        end else begin
          check("drop_cnt", o_drop_cnt, expCnt.pop_front());
        end
      end
    end
  end

  initial begin
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    check("rst_drive", o_driveNext, 0);
    check("rst_data", o_data, 0);
    check("rst_err", o_err, 0);
    check("rst_cnt", o_drop_cnt, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    #1 check("rst_free", o_free, 1);

    // back-to-back tokens, consumer always ready
    for (int i = 0; i < 4; i++) begin
      logic [NP-1:0] s;
      s = NP'(1) << i;
      push(s, 32'hA0 + i);
      cyc(1'b1, s, 32'hA0 + i, 4'b1111, 1'b1);
    end
    cyc(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);
    cyc(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);

    // port 2 stalls three cycles; offered tokens must be ignored
    for (int i = 0; i < 4; i++) push(4'b0100, 32'h55);
    cyc(1'b1, 4'b0100, 32'h55, 4'b1111, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0001, 32'h77, 4'b1011, 1'b0);
    cyc(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);
    cyc(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);

    // illegal selects
    expCnt.push_back(2'd1);
    cyc(1'b1, 4'b0000, 32'hE0, 4'b1111, 1'b1);
`ifdef C_SELECTOR_N_BROADCAST_EN
    push(4'b0011, 32'hE1);
`else
    expCnt.push_back(2'd2);
`endif
    cyc(1'b1, 4'b0011, 32'hE1, 4'b1111, 1'b1);
    cyc(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);
    cyc(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);
`ifdef C_SELECTOR_N_BROADCAST_EN
    check("cnt_after_illegal", o_drop_cnt, 1);
`else
    check("cnt_after_illegal", o_drop_cnt, 2);
`endif

    // saturation: fresh counter, five drops
    @(posedge clk);
    #1 rstn = 1'b0;
    #1 check("cnt_cleared", o_drop_cnt, 0);
    rstn = 1'b1;
    expCnt.push_back(2'd1);
    expCnt.push_back(2'd2);
    expCnt.push_back(2'd3);
    expCnt.push_back(2'd3);
    expCnt.push_back(2'd3);
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'b0000, 32'hD0, 4'b1111, 1'b1);
    cyc(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);
    cyc(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);
    check("cnt_saturated", o_drop_cnt, 3);

`ifdef C_SELECTOR_N_BROADCAST_EN
    // broadcast: ports 0,3 finish first, port 1 last
    push(4'b1011, 32'hB0);
    push(4'b0010, 32'hB0);
    push(4'b0010, 32'hB0);
    cyc(1'b1, 4'b1011, 32'hB0, 4'b1111, 1'b1);
    cyc(1'b0, 4'b0000, 32'h0, 4'b1001, 1'b0);
    cyc(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0000, 32'h0, 4'b0010, 1'b1);
    cyc(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);
`endif

    // reset while holding a token
    push(4'b0010, 32'h99);
    cyc(1'b1, 4'b0010, 32'h99, 4'b1111, 1'b1);
    cyc(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0);
    #1 rstn = 1'b0;
    #1;
    check("midrst_drive", o_driveNext, 0);
    check("midrst_data", o_data, 0);
    check("midrst_cnt", o_drop_cnt, 0);
    check("midrst_err", o_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    i_freeNext = 4'b1111;
    push(4'b0001, 32'h11);
    cyc(1'b1, 4'b0001, 32'h11, 4'b1111, 1'b1);
    cyc(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);
    cyc(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1);

    check("tokens_drained", expDrv.size(), 0);
    check("errs_drained", expCnt.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
